crc4_serial_tx: RTL and testbench
=================================

Name: crc4_serial_tx

Overview:
Serial frame transmitter that produces the bit streams our 4-bit serial-input signature register checks.
- Accepts a parallel DATA_W-bit word over a valid/ready handshake.
- Shifts the word out MSB-first, one bit per clock.
- Appends the 4-bit CRC remainder, MSB-first, using polynomial x^4+x+1.
- A receiving signature register fed the full frame from reset ends at 4'h0.
- Sits at the BIST/link source, facing the serial checker.

Parameters:
DATA_W, 8, payload bits per frame (legal range 1..32).
POLY, 4'b0011, low-order feedback taps of x^4+x+1 (bit0 and bit1 receive feedback).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
data_in  input  DATA_W  payload word, sampled on accept.
start  input  1  payload valid.
ready  output  1  transmitter can accept; accept = start & ready at a rising clk edge.
so  output  1  serial bit out.
so_valid  output  1  so carries a frame bit this cycle.
so_crc  output  1  so carries a CRC bit (last 4 bits of the frame).
so_last  output  1  final CRC bit of the frame is on so.

Behaviour:
- One clock domain; reset is asynchronous, active-high. All outputs except ready come directly from registers.
- Reset values:
  - state=IDLE, crc=4'h0, shift reg=0, counter=0.
  - so=0, so_valid=0, so_crc=0, so_last=0.
  - ready reads 1 while in IDLE. start is ignored while rst=1.
- States:
  - IDLE: so_valid=0.
  - DATA: DATA_W cycles.
  - CRC: 4 cycles.
- ready = (state==IDLE) | so_last. Back-to-back frames are therefore supported with zero gap.
- Accept at edge T:
  - Load data_in; crc<=0; enter DATA.
  - Cycle after T: so=data_in[DATA_W-1], so_valid=1.
  - Frame length is DATA_W+4 cycles.
- CRC update per data bit b, where c = crc[3:0] (Galois, matching the receiver):
  - fb = b ^ c[3].
  - c <= {c[2], c[1], c[0]^fb, fb}.
  - The update uses the bit being shifted out, so the CRC after the last data bit is final.
- CRC phase:
  - so = crc[3] each cycle; crc shifts left, filling with 0.
  - Sequence out: c3, c2, c1, c0.
  - so_crc=1 for all 4 cycles. so_last=1 on the c0 cycle only.
- Counter: clog2(DATA_W+4) bits, counts frame bits. There is no wrap beyond the frame; a terminal count moves the state to IDLE or directly to a new DATA.
- Accept during so_last:
  - The next cycle carries the new frame's MSB.
  - crc is cleared for the new frame in the same edge.
- No accept during so_last: the next cycle returns to IDLE with so_valid=0 and so=0.
- start while busy (ready=0): ignored and not queued. data_in is not sampled.
- Reset mid-frame: immediate abort; all outputs go to reset values. No partial CRC is emitted.

Decomposition:
- Shared package crc4_pkg holds:
  - the state encoding (IDLE, DATA, CRC);
  - the CRC width constant (4);
  - the POLY default 4'b0011.
- One sub-module: crc4_lfsr_step.
  - Combinational next-CRC function: inputs c[3:0] and b; output c_next.
  - Reused by the future parallel checker.

Test Plan:
1. Reset then idle: rst pulse mid-run; release; start=0 for 10 cycles -> so_valid=0, so=0, ready=1 throughout.
2. data_in=8'hA5, start 1 cycle -> so sequence 1,0,1,0,0,1,0,1 then CRC 1,0,1,1 (4'hB); so_crc high last 4 cycles; so_last on cycle 12; ready=0 cycles 1-11.
3. data_in=8'h00 -> 12 zero bits, CRC 4'h0. data_in=8'h01 -> CRC 4'h3. Each frame fed into the existing serial signature register from reset leaves it at 4'h0.
4. Back-to-back: frame A5 accepted, start held with data_in=8'h01 -> second accept at so_last. Next cycle shows so=0, so_valid=1 (gapless). Second CRC = 4'h3, proving the CRC was cleared.
5. start pulsed with data_in=8'hFF while busy in the DATA phase -> ignored; the frame in flight is unchanged.
6. rst asserted during the 3rd CRC bit -> outputs reset asynchronously (before the next edge). After release, a fresh frame 8'hA5 reproduces scenario 2 exactly.

Source files
------------

// File: rtl/crc4_pkg.sv
// Shared definitions for the 4-bit CRC serial transmitter and its future parallel checker.
// Holds the FSM state encoding, the CRC width and the default x^4+x+1 feedback taps.
package crc4_pkg;

    localparam int CRC_W = 4;

    // Low-order taps of x^4+x+1; the x^4 term is implicit in the shift.
    localparam logic [CRC_W-1:0] CRC_POLY = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CRC  = 2'd2
    } state_t;

endpackage

// File: rtl/crc4_lfsr_step.sv
// One serial step of the Galois CRC register: fb = b ^ c[msb], shift left, XOR fb into the taps.
// Purely combinational so the same step can be unrolled by a parallel checker.
module crc4_lfsr_step
    import crc4_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = CRC_POLY
) (
    input  logic [CRC_W-1:0] c,
    input  logic             b,
    output logic [CRC_W-1:0] c_next
);

    logic fb;
    assign fb = b ^ c[CRC_W-1];

    genvar gi;
    generate
        for (gi = 0; gi < CRC_W; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign c_next[gi] = POLY[gi] & fb;
            end else begin : g_upper
                assign c_next[gi] = c[gi-1] ^ (POLY[gi] & fb);
            end
        end
    endgenerate

endmodule

// File: rtl/crc4_serial_tx.sv
// Serial frame transmitter: DATA_W payload bits MSB-first followed by the 4-bit CRC remainder.
// A receiving signature register clocked with the whole frame from zero ends at 4'h0.
module crc4_serial_tx
    import crc4_pkg::*;
#(
    parameter int               DATA_W = 8,
    parameter logic [CRC_W-1:0] POLY   = CRC_POLY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              start,
    output logic              ready,
    output logic              so,
    output logic              so_valid,
    output logic              so_crc,
    output logic              so_last
);

    localparam int FRAME_LEN = DATA_W + CRC_W;
    localparam int CNT_W     = $clog2(FRAME_LEN);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t LAST_DATA   = cnt_t'(DATA_W - 1);
    localparam cnt_t BEFORE_LAST = cnt_t'(FRAME_LEN - 2);
    localparam cnt_t LAST_BIT    = cnt_t'(FRAME_LEN - 1);

    state_t            state_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [CRC_W-1:0]  crc_reg;
    logic [CRC_W-1:0]  crc_next;
    cnt_t              cnt_reg;
    logic              so_reg;
    logic              so_valid_reg;
    logic              so_crc_reg;
    logic              so_last_reg;
    logic              accept;

    // The CRC absorbs the bit currently on the line, so it is final once the last data bit leaves.
    crc4_lfsr_step #(
        .POLY (POLY)
    ) u_step (
        .c      (crc_reg),
        .b      (so_reg),
        .c_next (crc_next)
    );

    assign ready    = (state_reg == ST_IDLE) | so_last_reg;
    assign accept   = start & ready;
    assign so       = so_reg;
    assign so_valid = so_valid_reg;
    assign so_crc   = so_crc_reg;
    assign so_last  = so_last_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= '0;
            crc_reg      <= '0;
            cnt_reg      <= '0;
            so_reg       <= 1'b0;
            so_valid_reg <= 1'b0;
            so_crc_reg   <= 1'b0;
            so_last_reg  <= 1'b0;
        end else if (accept) begin
            // The MSB goes straight to the line; the shift register keeps the remaining bits.
            state_reg    <= ST_DATA;
            shift_reg    <= data_in << 1;
            crc_reg      <= '0;
            cnt_reg      <= '0;
            so_reg       <= data_in[DATA_W-1];
            so_valid_reg <= 1'b1;
            so_crc_reg   <= 1'b0;
            so_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_DATA: begin
                    crc_reg <= crc_next;
                    cnt_reg <= cnt_reg + cnt_t'(1);
                    if (cnt_reg == LAST_DATA) begin
                        state_reg  <= ST_CRC;
                        so_reg     <= crc_next[CRC_W-1];
                        so_crc_reg <= 1'b1;
                    end else begin
                        so_reg    <= shift_reg[DATA_W-1];
                        shift_reg <= shift_reg << 1;
                    end
                end
                ST_CRC: begin
                    if (cnt_reg == LAST_BIT) begin
                        state_reg    <= ST_IDLE;
                        cnt_reg      <= '0;
                        so_reg       <= 1'b0;
                        so_valid_reg <= 1'b0;
                        so_crc_reg   <= 1'b0;
                        so_last_reg  <= 1'b0;
                    end else begin
                        cnt_reg     <= cnt_reg + cnt_t'(1);
                        crc_reg     <= {crc_reg[CRC_W-2:0], 1'b0};
                        so_reg      <= crc_reg[CRC_W-2];
                        so_last_reg <= (cnt_reg == BEFORE_LAST);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc4_serial_tx.sv
// Randomised self-checking bench: a queue of expected frame bits built by polynomial long division
// is compared against the serial outputs every cycle, plus literal frame and signature checks.
module tb_crc4_serial_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         ready;
    logic         so;
    logic         so_valid;
    logic         so_crc;
    logic         so_last;

    int total = 0;
    int bad   = 0;

    crc4_serial_tx #(
        .DATA_W (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .start    (start),
        .ready    (ready),
        .so       (so),
        .so_valid (so_valid),
        .so_crc   (so_crc),
        .so_last  (so_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Remainder of d * x^4 divided by x^4+x+1.
    function automatic logic [3:0] ref_crc(input logic [W-1:0] d);
        logic [W+3:0] r;
        r = {d, 4'b0000};
        for (int i = W + 3; i >= 4; i--) begin
            if (r[i]) r[i-:5] = r[i-:5] ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    // Expected line contents: {bit, is_crc, is_last}; head is the bit on so this cycle.
    logic [2:0] q[$];
    logic       m_acc;
    logic [3:0] m_crc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else begin
            m_acc = start && (q.size() <= 1);
            if (q.size() > 0) void'(q.pop_front());
            if (m_acc) begin
                m_crc = ref_crc(data_in);
                for (int i = W - 1; i >= 0; i--) q.push_back({data_in[i], 2'b00});
                for (int i = 3; i >= 0; i--) q.push_back({m_crc[i], 1'b1, (i == 0)});
            end
        end
    end

    logic [3:0] exp_line;
    always @(negedge clk) begin
        exp_line = (q.size() > 0) ? {q[0][2], 1'b1, q[0][1], q[0][0]} : 4'b0000;
        check("cycle {so,valid,crc,last,ready}", {27'd0, so, so_valid, so_crc, so_last, ready},
              {27'd0, exp_line, (q.size() <= 1)});
    end

    // Serial signature register on the receiving side.
    logic [3:0] sig = 4'h0;
    logic       sig_fb;
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            sig = 4'h0;
        end else if (so_valid) begin
            sig_fb = so ^ sig[3];
            sig = {sig[2:0], 1'b0} ^ ({4{sig_fb}} & 4'b0011);
            if (so_last) begin
                check("signature", {28'd0, sig}, 32'd0);
                sig = 4'h0;
            end
        end
    end

    logic [63:0] cap;
    int          ncap;
    always @(negedge clk) begin
        if (so_valid) begin
            cap = {cap[62:0], so};
            ncap++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (q.size() > 1 && n < 200) begin
            idle(1);
            n++;
        end
        if (n >= 200) check("wait_ready timeout", 1, 0);
    endtask

    task automatic send(input logic [W-1:0] d);
        wait_ready();
        data_in = d;
        start   = 1'b1;
        idle(1);
        start   = 1'b0;
    endtask

    task automatic frame_check(input string name, input logic [W-1:0] d, input logic [11:0] exp);
        cap  = '0;
        ncap = 0;
        send(d);
        idle(12);
        check(name, {20'd0, cap[11:0]}, {20'd0, exp});
        check({name, " length"}, ncap, 12);
    endtask

    initial begin
        // Model pinned to hand-computed remainders.
        check("model crc A5", {28'd0, ref_crc(8'hA5)}, 32'hB);
        check("model crc 00", {28'd0, ref_crc(8'h00)}, 32'h0);
        check("model crc 01", {28'd0, ref_crc(8'h01)}, 32'h3);

        #2;
        idle(2);
        rst = 1'b0;
        idle(3);

        // Reset pulse mid-run, then a quiet idle period.
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        idle(1);
        idle(10);

        frame_check("frame A5", 8'hA5, 12'hA5B);
        frame_check("frame 00", 8'h00, 12'h000);
        frame_check("frame 01", 8'h01, 12'h013);

        // Back-to-back: start held so the second word is taken during so_last.
        cap  = '0;
        ncap = 0;
        data_in = 8'hA5;
        start   = 1'b1;
        idle(1);
        data_in = 8'h01;
        idle(12);
        start = 1'b0;
        idle(12);
        check("back-to-back bits", {8'd0, cap[23:0]}, {8'd0, 24'hA5B013});
        check("back-to-back length", ncap, 24);

        // start while busy in DATA is ignored.
        cap  = '0;
        ncap = 0;
        send(8'hA5);
        idle(3);
        data_in = 8'hFF;
        start   = 1'b1;
        idle(1);
        start   = 1'b0;
        idle(8);
        check("busy start ignored", {20'd0, cap[11:0]}, {20'd0, 12'hA5B});
        check("busy start length", ncap, 12);

        // Asynchronous reset during the third CRC bit.
        send(8'hA5);
        repeat (10) @(posedge clk);
        #3;
        check("third crc bit flags", {30'd0, so_crc, so_last}, 32'b10);
        check("third crc bit value", {31'd0, so}, 32'd1);
        rst = 1'b1;
        #1;
        check("async reset outputs", {27'd0, so, so_valid, so_crc, so_last, ready}, 32'b00001);
        @(posedge clk);
        #3 rst = 1'b0;
        idle(1);
        frame_check("frame A5 after reset", 8'hA5, 12'hA5B);

        // Randomised traffic with gaps, back-to-back and stray start pulses.
        for (int f = 0; f < 40; f++) begin
            idle($urandom_range(0, 3));
            send(W'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                idle($urandom_range(0, 12));
                data_in = W'($urandom);
                start   = 1'b1;
                idle(1);
                start   = 1'b0;
            end
        end
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
